// File: rtl/jt12_acc_mix.sv
// Per-channel carrier accumulator and stereo mixer for the 24-slot operator stream.
// Build option JT12_DAC_EN: channel 5 can be replaced by a direct DAC sample.
module jt12_acc_mix #(
  parameter int NUM_VOICES = 6,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    zero,
  input  logic signed [8:0]       op_result,
  input  logic                    s1_enters,
  input  logic                    s2_enters,
  input  logic                    s3_enters,
  input  logic                    s4_enters,
  input  logic [2:0]              alg,
  input  logic [1:0]              rl,
`ifdef JT12_DAC_EN
  input  logic                    dac_en,
  input  logic signed [8:0]       dac_val,
`endif
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample_valid,
  output logic signed [11:0]      ch_sum,
  output logic [2:0]              ch_idx
);

  logic [4:0] cnt_q;
  logic [4:0] cnt;
  logic [4:0] cnt_nxt;
  logic [2:0] ch_q;
  logic [2:0] ch;
  logic [2:0] ch_nxt;
  logic       resync;
  logic       frame_end;

  // Slot position is forced to 0 in the same cycle zero is seen
  assign cnt     = zero ? 5'd0 : cnt_q;
  assign ch      = zero ? 3'd0 : ch_q;
  assign cnt_nxt = (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
  assign ch_nxt  = (ch == 3'd5) ? 3'd0 : ch + 3'd1;
  assign resync  = zero && (cnt_q != 5'd0);

  logic signed [11:0] acc [NUM_VOICES];
  logic signed [11:0] acc_out;
  logic signed [11:0] acc_in;
  logic signed [11:0] opx;
  logic signed [11:0] c;
  logic signed [11:0] chan;
  logic               carrier;
  logic               is_s4;

  assign acc_out = acc[NUM_VOICES-1];
  assign opx     = {{3{op_result[8]}}, op_result};

  always_comb begin
    carrier = 1'b0;
    is_s4   = 1'b0;
    unique case (1'b1)
      s1_enters: carrier = (alg == 3'd7);
      s3_enters: carrier = (alg >= 3'd4);
      s2_enters: carrier = (alg >= 3'd5);
      s4_enters: begin
        carrier = 1'b1;
        is_s4   = 1'b1;
      end
      default: ;
    endcase
  end

  assign c = carrier ? opx : 12'sd0;

  always_comb begin
    chan = acc_out + c;
`ifdef JT12_DAC_EN
    if (dac_en && ch == 3'd5)
      chan = {{3{dac_val[8]}}, dac_val};
`endif
  end

  always_comb begin
    acc_in = acc_out;
    unique case (1'b1)
      s1_enters: acc_in = c;
      s3_enters: acc_in = acc_out + c;
      s2_enters: acc_in = acc_out + c;
      s4_enters: acc_in = 12'sd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++)
        acc[i] <= 12'sd0;
    end else begin
      acc[0] <= acc_in;
      for (int i = 1; i < NUM_VOICES; i++)
        acc[i] <= acc[i-1];
    end
  end

  logic signed [OUT_W-1:0] mix_l;
  logic signed [OUT_W-1:0] mix_r;
  logic signed [OUT_W-1:0] chan_x;
  logic signed [OUT_W-1:0] sum_l;
  logic signed [OUT_W-1:0] sum_r;

  assign chan_x    = {{(OUT_W-12){chan[11]}}, chan};
  assign sum_l     = mix_l + (rl[1] ? chan_x : '0);
  assign sum_r     = mix_r + (rl[0] ? chan_x : '0);
  assign frame_end = is_s4 && (cnt == 5'd23);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 5'd0;
      ch_q         <= 3'd0;
      mix_l        <= '0;
      mix_r        <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      ch_sum       <= 12'sd0;
      ch_idx       <= 3'd0;
    end else begin
      cnt_q        <= cnt_nxt;
      ch_q         <= ch_nxt;
      sample_valid <= 1'b0;
      if (is_s4) begin
        ch_sum <= chan;
        ch_idx <= ch;
      end
      if (resync) begin
        mix_l <= '0;
        mix_r <= '0;
      end else if (frame_end) begin
        left         <= sum_l;
        right        <= sum_r;
        mix_l        <= '0;
        mix_r        <= '0;
        sample_valid <= 1'b1;
      end else if (is_s4) begin
        mix_l <= sum_l;
        mix_r <= sum_r;
      end
    end
  end

endmodule

// File: tb/tb_jt12_acc_mix.sv
// Directed-vector bench for jt12_acc_mix.
// Build option JT12_DAC_EN enables the DAC replacement vector.
module tb_jt12_acc_mix;

  logic              clk = 1'b0;
  logic              rst;
  logic              zero;
  logic signed [8:0] op_result;
  logic              s1_enters, s2_enters, s3_enters, s4_enters;
  logic [2:0]        alg;
  logic [1:0]        rl;
  logic signed [15:0] left, right;
  logic              sample_valid;
  logic signed [11:0] ch_sum;
  logic [2:0]        ch_idx;
`ifdef JT12_DAC_EN
  logic              dac_en;
  logic signed [8:0] dac_val;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [2:0]        alg_t [6];
  logic [1:0]        rl_t  [6];
  logic signed [8:0] op_t  [4];
  int                exp_cs[6];

  always #5 clk = ~clk;

  jt12_acc_mix dut (
    .clk(clk),
    .rst(rst),
    .zero(zero),
    .op_result(op_result),
    .s1_enters(s1_enters),
    .s2_enters(s2_enters),
    .s3_enters(s3_enters),
    .s4_enters(s4_enters),
    .alg(alg),
    .rl(rl),
`ifdef JT12_DAC_EN
    .dac_en(dac_en),
    .dac_val(dac_val),
`endif
    .left(left),
    .right(right),
    .sample_valid(sample_valid),
    .ch_sum(ch_sum),
    .ch_idx(ch_idx)
  );

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Slot s: group order S1,S3,S2,S4; channel = s%6
  task automatic drive(input int s, input bit z);
    int g, ch;
    g = s / 6;
    ch = s % 6;
    @(negedge clk);
    zero      = z;
    s1_enters = (g == 0);
    s3_enters = (g == 1);
    s2_enters = (g == 2);
    s4_enters = (g == 3);
    op_result = op_t[g];
    alg       = alg_t[ch];
    rl        = rl_t[ch];
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input int el, input int er);
    for (int s = 0; s < n; s++) begin
      drive(s, s == 0);
      if (s / 6 == 3) begin
        check("ch_sum", ch_sum, exp_cs[s % 6]);
        check("ch_idx", ch_idx, s % 6);
      end
      if (s == 23) begin
        check("valid", sample_valid, 1);
        check("left", left, el);
        check("right", right, er);
      end else begin
        check("novalid", sample_valid, 0);
      end
    end
  endtask

  task automatic cfg(input int a, input int r, input int o1, input int o3,
                     input int o2, input int o4, input int cs);
    for (int i = 0; i < 6; i++) begin
      alg_t[i]  = 3'(a);
      rl_t[i]   = 2'(r);
      exp_cs[i] = cs;
    end
    op_t[0] = 9'(o1);
    op_t[1] = 9'(o3);
    op_t[2] = 9'(o2);
    op_t[3] = 9'(o4);
  endtask

  task automatic cfg_mixed();
    cfg(0, 0, 1, 2, 4, 8, 0);
    alg_t  = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    rl_t   = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
    exp_cs = '{8, 8, 10, 14, 14, 15};
  endtask

  initial begin
    rst = 1'b1;
    zero = 1'b0;
    op_result = '0;
    {s1_enters, s2_enters, s3_enters, s4_enters} = '0;
    alg = '0;
    rl = '0;
`ifdef JT12_DAC_EN
    dac_en = 1'b0;
    dac_val = '0;
`endif
    cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_left", left, 0);
    check("rst_right", right, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_chsum", ch_sum, 0);
    check("rst_chidx", ch_idx, 0);
    rst = 1'b0;

    // all carriers, +10 each: 40 per channel, 240 total
    cfg(7, 3, 10, 10, 10, 10, 40);
    run_frame(24, 240, 240);
    run_frame(24, 240, 240);

    // only S4 reaches the output under alg0
    cfg(0, 3, 100, 100, 100, -5, -5);
    run_frame(24, -30, -30);

    // ch0 left only, min operator value
    cfg(7, 0, -256, -256, -256, -256, -1024);
    rl_t[0] = 2'b10;
    run_frame(24, -1024, 0);

    cfg_mixed();
    run_frame(24, 47, 33);

    // resync at cnt=10, outputs hold, next frame complete
    cfg(7, 3, 10, 10, 10, 10, 40);
    run_frame(10, 0, 0);
    check("hold_left", left, 47);
    check("hold_right", right, 33);
    run_frame(24, 240, 240);

    // resync at cnt=21 after partial mixing must drop the partial sums
    cfg(7, 3, -256, -256, -256, -256, -1024);
    run_frame(21, 0, 0);
    check("hold2_left", left, 240);
    cfg(7, 3, 10, 10, 10, 10, 40);
    run_frame(24, 240, 240);

    // reset mid-frame at cnt=16
    cfg_mixed();
    run_frame(16, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_left", left, 0);
    check("mrst_right", right, 0);
    check("mrst_valid", sample_valid, 0);
    check("mrst_chsum", ch_sum, 0);
    rst = 1'b0;
    run_frame(24, 47, 33);

`ifdef JT12_DAC_EN
    cfg(7, 3, 0, 0, 0, 0, 0);
    exp_cs[5] = -100;
    dac_en  = 1'b1;
    dac_val = -9'sd100;
    run_frame(24, -100, -100);
    dac_en  = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
